// File: rtl/labyrinth_pkg.sv
// Shared types and defaults for the labyrinth game display control path.
package labyrinth_pkg;

  localparam int         V_ACTIVE_DEF = 480;
  localparam logic [9:0] START_X_DEF  = 10'd16;
  localparam logic [9:0] START_Y_DEF  = 10'd16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PLAY    = 3'd1,
    ST_HOLE    = 3'd2,
    ST_RESPAWN = 3'd3,
    ST_WON     = 3'd4,
    ST_LOST    = 3'd5
  } state_e;

  // Registered overlay/control outputs, grouped so they update together.
  typedef struct packed {
    logic won;
    logic hit;
    logic phys_en;
    logic respawn;
  } ovl_t;

  // Frame counter is never narrower than 6 bits.
  function automatic int cnt_width(input int frames);
    int w;
    w = $clog2(frames + 1);
    return (w < 6) ? 6 : w;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// One-cycle pulse on the first cycle the raster reaches the first non-visible row.
module frame_tick_gen
  import labyrinth_pkg::*;
#(
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pixel_row,
  output logic       frame_tick
);

  logic row_hit, row_hit_q;

  assign row_hit = (pixel_row == 10'(V_ACTIVE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) row_hit_q <= 1'b0;
    else        row_hit_q <= row_hit;
  end

  assign frame_tick = row_hit & ~row_hit_q;

endmodule

// File: rtl/vga_frame_ctrl.sv
// Game-flow FSM, lives/hole-frame counters and frame-stable ball location latch.
module vga_frame_ctrl
  import labyrinth_pkg::*;
#(
  parameter int         V_ACTIVE    = V_ACTIVE_DEF,
  parameter int         HOLE_FRAMES = 60,
  parameter int         LIVES       = 3,
  parameter logic [9:0] START_X     = START_X_DEF,
  parameter logic [9:0] START_Y     = START_Y_DEF
) (
  input  logic       clk,
  input  logic       sys_rst,
  input  logic       start_btn,
  input  logic [9:0] pixel_row,
  input  logic [9:0] phys_loc_X,
  input  logic [9:0] phys_loc_Y,
  input  logic       hole_evt,
  input  logic       goal_evt,
  output logic [9:0] ball_loc_X,
  output logic [9:0] ball_loc_Y,
  output logic       won_the_game,
  output logic       hit_a_hole,
  output logic       phys_en,
  output logic       ball_respawn,
  output logic [1:0] lives_left,
  output logic [2:0] state_o
);

  localparam int             CNT_W    = cnt_width(HOLE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLE_FRAMES - 1);

  state_e           state_q, state_d;
  ovl_t             ovl_d, ovl_q;
  logic             start_q, start_rise, frame_tick, hole_done;
  logic [CNT_W-1:0] frame_cnt;
  logic [1:0]       lives_q;
  logic [9:0]       loc_x_q, loc_y_q;

  frame_tick_gen #(.V_ACTIVE(V_ACTIVE)) u_tick (
    .clk       (clk),
    .rst_n     (sys_rst),
    .pixel_row (pixel_row),
    .frame_tick(frame_tick)
  );

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) start_q <= 1'b0;
    else          start_q <= start_btn;
  end

  assign start_rise = start_btn & ~start_q;
  assign hole_done  = frame_tick && (frame_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start_rise) state_d = ST_RESPAWN;
      ST_RESPAWN: if (frame_tick) state_d = ST_PLAY;
      // goal wins over a simultaneous hole
      ST_PLAY: begin
        if (goal_evt)      state_d = ST_WON;
        else if (hole_evt) state_d = ST_HOLE;
      end
      ST_HOLE:    if (hole_done) state_d = (lives_q != 2'd0) ? ST_RESPAWN : ST_LOST;
      ST_WON,
      ST_LOST:    if (start_rise) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    ovl_d         = '0;
    ovl_d.won     = (state_d == ST_WON);
    ovl_d.hit     = (state_d == ST_HOLE) || (state_d == ST_LOST);
    ovl_d.phys_en = (state_d == ST_PLAY);
    ovl_d.respawn = (state_d == ST_RESPAWN) && (state_q != ST_RESPAWN);
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) ovl_q <= '0;
    else          ovl_q <= ovl_d;
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      lives_q   <= 2'd0;
      frame_cnt <= '0;
    end else begin
      if (state_q == ST_IDLE && state_d == ST_RESPAWN)
        lives_q <= 2'(LIVES);
      else if (state_q == ST_PLAY && state_d == ST_HOLE && lives_q != 2'd0)
        lives_q <= lives_q - 2'd1;
      // held at zero outside HOLE, so every HOLE entry starts from zero
      if (state_q != ST_HOLE)
        frame_cnt <= '0;
      else if (frame_tick && frame_cnt != '1)
        frame_cnt <= frame_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      loc_x_q <= START_X;
      loc_y_q <= START_Y;
    end else if (frame_tick) begin
      loc_x_q <= phys_loc_X;
      loc_y_q <= phys_loc_Y;
    end
  end

  assign ball_loc_X   = loc_x_q;
  assign ball_loc_Y   = loc_y_q;
  assign won_the_game = ovl_q.won;
  assign hit_a_hole   = ovl_q.hit;
  assign phys_en      = ovl_q.phys_en;
  assign ball_respawn = ovl_q.respawn;
  assign lives_left   = lives_q;
  assign state_o      = state_q;

endmodule
